// File: rtl/lbg_conv_ctrl.sv
// LBG codebook-training loop controller.
// Sequences distortion passes and codebook updates until convergence or MAX_ITER.
module lbg_conv_ctrl #(
    parameter int unsigned EPS_SHIFT = 7,
    parameter int unsigned MAX_ITER  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        START,
    output logic        D_CLEAR,
    output logic        D_START,
    input  logic        D_FINSH,
    input  logic [44:0] D1,
    output logic        CB_UPDATE_START,
    input  logic        CB_UPDATE_FINSH,
    output logic        BUSY,
    output logic        FINSH,
    output logic        CONVERGED,
    output logic [5:0]  ITER_CNT,
    output logic [44:0] D_PREV
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_WAIT_D,
        S_LATCH,
        S_CHECK,
        S_UPD,
        S_WAIT_U,
        S_DONE
    } state_t;

    localparam logic [5:0] ITER_LIMIT = 6'(MAX_ITER);

    state_t      state_q, state_d;
    logic        d_clear_q, d_clear_d;
    logic        d_start_q, d_start_d;
    logic        cb_start_q, cb_start_d;
    logic        finsh_q, finsh_d;
    logic        busy_q, busy_d;
    logic        conv_q, conv_d;
    logic        first_q, first_d;
    logic [5:0]  iter_q, iter_d;
    logic [44:0] d_prev_q, d_prev_d;
    logic [44:0] d_cur_q, d_cur_d;

    logic        d_rise;
    logic        d_zero;
    logic        d_small;
    logic        conv_hit;

    // Convergence test; the difference is only meaningful when no increase occurred.
    always_comb begin
        d_rise   = d_cur_q > d_prev_q;
        d_zero   = d_cur_q == '0;
        d_small  = 1'b0;
        if (!d_rise) begin
            d_small = (d_prev_q - d_cur_q) <= (d_cur_q >> EPS_SHIFT);
        end
        conv_hit = d_rise || d_zero || d_small;
    end

    // Next-state and next-output logic; pulses are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        d_clear_d  = 1'b0;
        d_start_d  = 1'b0;
        cb_start_d = 1'b0;
        finsh_d    = 1'b0;
        conv_d     = conv_q;
        first_d    = first_q;
        iter_d     = iter_q;
        d_prev_d   = d_prev_q;
        d_cur_d    = d_cur_q;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_CLR;
                    d_clear_d = 1'b1;
                    iter_d    = '0;
                    first_d   = 1'b1;
                    conv_d    = 1'b0;
                end
            end
            S_CLR: begin
                state_d   = S_RUN;
                d_start_d = 1'b1;
            end
            S_RUN: begin
                state_d = S_WAIT_D;
            end
            S_WAIT_D: begin
                if (D_FINSH) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                d_cur_d = D1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (first_q) begin
                    d_prev_d   = d_cur_q;
                    first_d    = 1'b0;
                    state_d    = S_UPD;
                    cb_start_d = 1'b1;
                end else if (conv_hit) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                    finsh_d = 1'b1;
                end else if (iter_q == ITER_LIMIT) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                    finsh_d = 1'b1;
                end else begin
                    d_prev_d   = d_cur_q;
                    state_d    = S_UPD;
                    cb_start_d = 1'b1;
                end
            end
            S_UPD: begin
                iter_d  = iter_q + 6'd1;
                state_d = S_WAIT_U;
            end
            S_WAIT_U: begin
                if (CB_UPDATE_FINSH) begin
                    state_d   = S_CLR;
                    d_clear_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = state_d != S_IDLE;
    end

    // State and registered outputs, with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            d_clear_q  <= 1'b0;
            d_start_q  <= 1'b0;
            cb_start_q <= 1'b0;
            finsh_q    <= 1'b0;
            busy_q     <= 1'b0;
            conv_q     <= 1'b0;
            first_q    <= 1'b1;
            iter_q     <= '0;
            d_prev_q   <= '0;
            d_cur_q    <= '0;
        end else begin
            state_q    <= state_d;
            d_clear_q  <= d_clear_d;
            d_start_q  <= d_start_d;
            cb_start_q <= cb_start_d;
            finsh_q    <= finsh_d;
            busy_q     <= busy_d;
            conv_q     <= conv_d;
            first_q    <= first_d;
            iter_q     <= iter_d;
            d_prev_q   <= d_prev_d;
            d_cur_q    <= d_cur_d;
        end
    end

    assign D_CLEAR         = d_clear_q;
    assign D_START         = d_start_q;
    assign CB_UPDATE_START = cb_start_q;
    assign FINSH           = finsh_q;
    assign BUSY            = busy_q;
    assign CONVERGED       = conv_q;
    assign ITER_CNT        = iter_q;
    assign D_PREV          = d_prev_q;

endmodule

// File: tb/tb_lbg_conv_ctrl.sv
// Directed bench for lbg_conv_ctrl with a result scoreboard.
// Expected loop outcomes are queued at stimulus time and popped on FINSH.
module tb_lbg_conv_ctrl;

    localparam int MAXI = 3;

    typedef struct packed {
        logic        conv;
        logic [5:0]  iter;
        logic [44:0] dprev;
        logic [31:0] npass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        START = 1'b0;
    logic        D_FINSH = 1'b0;
    logic        CB_UPDATE_FINSH = 1'b0;
    logic [44:0] D1 = '0;
    logic        D_CLEAR, D_START, CB_UPDATE_START, FINSH, BUSY, CONVERGED;
    logic [5:0]  ITER_CNT;
    logic [44:0] D_PREV;

    int total = 0;
    int bad = 0;

    exp_t        exp_q[$];
    logic [44:0] seq_q[$];

    int n_clr = 0, n_dst = 0, n_upd = 0, n_fin = 0, viol = 0;
    int s_clr, s_dst, s_upd, s_fin;
    logic p_clr = 0, p_dst = 0, p_upd = 0, p_fin = 0;

    lbg_conv_ctrl #(.EPS_SHIFT(7), .MAX_ITER(MAXI)) dut (
        .clk(clk),
        .rst(rst),
        .START(START),
        .D_CLEAR(D_CLEAR),
        .D_START(D_START),
        .D_FINSH(D_FINSH),
        .D1(D1),
        .CB_UPDATE_START(CB_UPDATE_START),
        .CB_UPDATE_FINSH(CB_UPDATE_FINSH),
        .BUSY(BUSY),
        .FINSH(FINSH),
        .CONVERGED(CONVERGED),
        .ITER_CNT(ITER_CNT),
        .D_PREV(D_PREV)
    );

    always #5 clk = ~clk;

    // Pulse counters and back-to-back pulse detector.
    always @(negedge clk) begin
        if (D_CLEAR === 1'b1) n_clr++;
        if (D_START === 1'b1) n_dst++;
        if (CB_UPDATE_START === 1'b1) n_upd++;
        if (FINSH === 1'b1) n_fin++;
        if ((p_clr && D_CLEAR) || (p_dst && D_START) ||
            (p_upd && CB_UPDATE_START) || (p_fin && FINSH)) viol++;
        p_clr = D_CLEAR === 1'b1;
        p_dst = D_START === 1'b1;
        p_upd = CB_UPDATE_START === 1'b1;
        p_fin = FINSH === 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_clr = n_clr;
        s_dst = n_dst;
        s_upd = n_upd;
        s_fin = n_fin;
    endtask

    task automatic push_exp(input logic c, input int it, input logic [44:0] dp,
                            input int np);
        exp_t e;
        e.conv  = c;
        e.iter  = 6'(it);
        e.dprev = dp;
        e.npass = 32'(np);
        exp_q.push_back(e);
    endtask

    // Reference outcome of the epsilon / iteration-limit loop for seq_q.
    function automatic exp_t model();
        exp_t        r;
        logic [44:0] prev;
        logic [44:0] cur;
        int          it;
        bit          first;
        r     = '0;
        prev  = '0;
        it    = 0;
        first = 1'b1;
        foreach (seq_q[i]) begin
            cur     = seq_q[i];
            r.npass = 32'(i + 1);
            if (first) begin
                prev  = cur;
                first = 1'b0;
                it++;
                continue;
            end
            if (cur > prev || cur == 0 || (prev - cur) <= (cur >> 7)) begin
                r.conv = 1'b1;
                break;
            end
            if (it == MAXI) begin
                r.conv = 1'b0;
                break;
            end
            prev = cur;
            it++;
        end
        r.iter  = 6'(it);
        r.dprev = prev;
        return r;
    endfunction

    task automatic wait_dstart(output int c);
        c = -1;
        for (int i = 0; i < 12; i++) begin
            if (D_START === 1'b1) begin
                c = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic quiet(input string tag, input logic busy_exp);
        check(tag, {D_CLEAR, D_START, CB_UPDATE_START, FINSH, BUSY},
              {4'b0000, busy_exp});
    endtask

    // Plays the distortion and update stages for one loop over seq_q.
    task automatic run_loop(input bit noise, input bit started);
        int   k;
        int   c;
        int   lat;
        bit   done;
        exp_t e;
        k    = 0;
        done = 1'b0;
        if (!started) begin
            snap();
            START = 1'b1;
            @(negedge clk);
            START = 1'b0;
        end
        while (!done && k < seq_q.size()) begin
            if (!(started && k == 0)) begin
                wait_dstart(c);
                if (c < 0) begin
                    check("dstart_timeout", 0, 1);
                    return;
                end
            end
            @(negedge clk);
            if (noise) begin
                START = 1'b1;
                CB_UPDATE_FINSH = 1'b1;
                @(negedge clk);
                START = 1'b0;
                CB_UPDATE_FINSH = 1'b0;
                quiet("noise_wait_d", 1'b1);
            end
            D1 = seq_q[k];
            D_FINSH = 1'b1;
            CB_UPDATE_FINSH = noise;
            @(negedge clk);
            D_FINSH = 1'b0;
            CB_UPDATE_FINSH = 1'b0;
            lat = 1;
            while (!(CB_UPDATE_START === 1'b1 || FINSH === 1'b1) && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            k++;
            if (FINSH === 1'b1) begin
                check("finsh_latency", 64'(lat), 64'd3);
                done = 1'b1;
            end else if (CB_UPDATE_START === 1'b1) begin
                check("upd_latency", 64'(lat), 64'd3);
                @(negedge clk);
                if (noise) begin
                    START = 1'b1;
                    D_FINSH = 1'b1;
                    @(negedge clk);
                    START = 1'b0;
                    D_FINSH = 1'b0;
                    quiet("noise_wait_u", 1'b1);
                end
                CB_UPDATE_FINSH = 1'b1;
                @(negedge clk);
                CB_UPDATE_FINSH = 1'b0;
            end else begin
                check("resp_timeout", 0, 1);
                return;
            end
        end
        check("finsh_seen", 64'(done), 64'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("converged", 64'(CONVERGED), 64'(e.conv));
        check("iter_cnt", 64'(ITER_CNT), 64'(e.iter));
        check("d_prev", 64'(D_PREV), 64'(e.dprev));
        check("passes", 64'(k), 64'(e.npass));
        @(negedge clk);
        quiet("after_finsh", 1'b0);
        check("n_d_start", 64'(n_dst - s_dst), 64'(e.npass));
        check("n_d_clear", 64'(n_clr - s_clr), 64'(e.npass));
        check("n_cb_start", 64'(n_upd - s_upd), 64'(e.iter));
        check("n_finsh", 64'(n_fin - s_fin), 64'd1);
        check("hold_conv", 64'(CONVERGED), 64'(e.conv));
        check("hold_iter", 64'(ITER_CNT), 64'(e.iter));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        exp_t m;

        repeat (3) @(negedge clk);
        quiet("reset_outputs", 1'b0);
        check("reset_conv", 64'(CONVERGED), 64'd0);
        check("reset_iter", 64'(ITER_CNT), 64'd0);
        check("reset_dprev", 64'(D_PREV), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        quiet("post_reset", 1'b0);

        seq_q = {45'd1000000, 45'd900000, 45'd899000};
        push_exp(1'b1, 2, 45'd900000, 3);
        run_loop(1'b0, 1'b0);

        seq_q = {45'd1000000, 45'd500000, 45'd250000, 45'd125000, 45'd60000};
        push_exp(1'b0, 3, 45'd250000, 4);
        run_loop(1'b0, 1'b0);

        seq_q = {45'd1000, 45'd1200};
        push_exp(1'b1, 1, 45'd1000, 2);
        run_loop(1'b1, 1'b0);

        seq_q = {45'd500, 45'd0};
        push_exp(1'b1, 1, 45'd500, 2);
        run_loop(1'b0, 1'b0);

        seq_q = {45'd800, 45'd800};
        push_exp(1'b1, 1, 45'd800, 2);
        run_loop(1'b1, 1'b0);

        seq_q = {45'd2000, 45'd1008, 45'd1000, 45'd993};
        push_exp(1'b1, 3, 45'd1000, 4);
        run_loop(1'b0, 1'b0);

        D_FINSH = 1'b1;
        CB_UPDATE_FINSH = 1'b1;
        @(negedge clk);
        D_FINSH = 1'b0;
        CB_UPDATE_FINSH = 1'b0;
        quiet("idle_noise_1", 1'b0);
        @(negedge clk);
        quiet("idle_noise_2", 1'b0);

        for (int r = 0; r < 3; r++) begin
            seq_q.delete();
            v = int'($urandom_range(200000, 2000000));
            for (int i = 0; i < 6; i++) begin
                seq_q.push_back(45'(v));
                v = v - int'($urandom_range(0, 32'(v / 3)));
            end
            m = model();
            exp_q.push_back(m);
            run_loop(r[0], 1'b0);
        end

        seq_q = {45'd1000000};
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        wait_dstart(v);
        check("pre_reset_dstart", 64'(v >= 0), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        quiet("mid_reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        quiet("after_mid_reset", 1'b0);
        check("rst_conv", 64'(CONVERGED), 64'd0);
        check("rst_iter", 64'(ITER_CNT), 64'd0);
        check("rst_dprev", 64'(D_PREV), 64'd0);

        snap();
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        check("start_p1", {D_CLEAR, D_START}, 2'b10);
        @(negedge clk);
        check("start_p2", {D_CLEAR, D_START}, 2'b01);
        seq_q = {45'd1000, 45'd1200};
        push_exp(1'b1, 1, 45'd1000, 2);
        run_loop(1'b0, 1'b1);

        check("pulse_b2b", 64'(viol), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lbg_conv_ctrl.md
LBG_CONV_CTRL -- requirements
Module: lbg_conv_ctrl

Interface
REQ-001 Parameter EPS_SHIFT, default 7: convergence threshold epsilon = 2^-EPS_SHIFT.
REQ-002 Parameter MAX_ITER, default 20: maximum codebook-update iterations per split level (1..63).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 START  in  1  one-cycle pulse that begins the iteration loop for the current split level.
REQ-007 D_CLEAR  out  1  one-cycle pulse that clears the distortion accumulator stage.
REQ-008 D_START  out  1  one-cycle pulse that starts a distortion pass.
REQ-009 D_FINSH  in  1  pulse from the distortion stage marking pass completion.
REQ-010 D1  in  45  accumulated distortion, unsigned.
REQ-011 CB_UPDATE_START  out  1  one-cycle pulse that starts the centroid/codebook update.
REQ-012 CB_UPDATE_FINSH  in  1  pulse from the codebook update stage marking completion.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 FINSH  out  1  one-cycle pulse when the loop ends.
REQ-015 CONVERGED  out  1  1 = loop ended by the epsilon test; 0 = ended by MAX_ITER.
REQ-016 ITER_CNT  out  6  number of codebook updates issued in the current loop.
REQ-017 D_PREV  out  45  distortion of the previous pass.

Function
REQ-018 FSM states: IDLE, CLR, RUN, WAIT_D, LATCH, CHECK, UPD, WAIT_U, DONE.
REQ-019 IDLE: on START go to CLR; clear ITER_CNT to 0; set the internal first_pass flag; clear CONVERGED.
REQ-020 CLR: assert D_CLEAR for exactly one cycle, then go to RUN.
REQ-021 RUN: assert D_START for exactly one cycle, then go to WAIT_D.
REQ-022 WAIT_D: hold until D_FINSH = 1, then go to LATCH (one-cycle delay so the registered D1 has settled).
REQ-023 LATCH: register D_CUR <= D1, then go to CHECK.
REQ-024 CHECK, when first_pass = 1: load D_PREV <= D_CUR, clear first_pass, go to UPD.
REQ-025 CHECK, when first_pass = 0, the pass is converged if any of the following holds:
- D_CUR > D_PREV (distortion increased);
- D_CUR = 0;
- (D_PREV - D_CUR) <= (D_CUR >> EPS_SHIFT).
All arithmetic is 45-bit unsigned, and the subtraction is evaluated only when D_PREV >= D_CUR.
REQ-026 CHECK, converged: set CONVERGED = 1 and go to DONE.
REQ-027 CHECK, not converged and ITER_CNT = MAX_ITER: set CONVERGED = 0 and go to DONE.
REQ-028 CHECK, otherwise: set D_PREV <= D_CUR and go to UPD.
REQ-029 The convergence test takes priority over the MAX_ITER test in the same CHECK cycle.
REQ-030 UPD: assert CB_UPDATE_START for one cycle, increment ITER_CNT, go to WAIT_U.
REQ-031 WAIT_U: hold until CB_UPDATE_FINSH = 1, then go to CLR.
REQ-032 DONE: assert FINSH for one cycle, go to IDLE. CONVERGED, ITER_CNT and D_PREV hold their values until the next accepted START.
REQ-033 START received outside IDLE is ignored.
REQ-034 D_FINSH received outside WAIT_D is ignored.
REQ-035 CB_UPDATE_FINSH received outside WAIT_U is ignored.
REQ-036 D_FINSH and CB_UPDATE_FINSH arriving in the same cycle: only the one expected by the current state is acted on.
REQ-037 All pulse outputs (D_CLEAR, D_START, CB_UPDATE_START, FINSH) are registered and never high for two consecutive cycles.
REQ-038 Latency from START to D_START is 2 cycles (CLR, then RUN).
REQ-039 Latency from D_FINSH to CB_UPDATE_START or FINSH is 3 cycles.

Reset
REQ-040 While rst = 1 at a clock edge, the block enters IDLE regardless of the current state, including mid-pass.
REQ-041 Reset values: all pulse outputs 0, BUSY 0, CONVERGED 0, ITER_CNT 0, D_PREV 0, D_CUR 0, first_pass 1.
REQ-042 No output pulse is emitted in the cycle after reset deasserts.

Verification
REQ-043 EPS_SHIFT=7; START; D1 pass sequence 1000000, 900000, 899000 → CB_UPDATE_START pulses twice; FINSH pulse; CONVERGED=1; ITER_CNT=2; D_PREV=900000.
REQ-044 MAX_ITER=3; D1 sequence 1000000, 500000, 250000, 125000 → 3 updates; FINSH after the 4th pass; CONVERGED=0; ITER_CNT=3.
REQ-045 D1 sequence 1000, 1200 → CONVERGED=1 (distortion increase); ITER_CNT=1; D_PREV=1000.
REQ-046 Second pass D1=0 → CONVERGED=1 with no subtraction underflow.
REQ-047 Bursts of START, D_FINSH and CB_UPDATE_FINSH in the wrong states (e.g. D_FINSH during WAIT_U) → no state change and no extra pulses.
REQ-048 rst asserted during WAIT_D, then released; START issued → BUSY=0 and all outputs at reset values before START; D_CLEAR at cycle+1 and D_START at cycle+2 after START; first pass is treated as first_pass.
